// File: rtl/batch_buffer_mc.sv
// batch_buffer_mc: two-bank batch capture buffer. Captures BATCH_SIZE samples of
// NUM_CHANNELS parallel channels into one bank while the other bank is replayed
// RUNS times as sop/eop-framed packets, one packet per channel per run.
module batch_buffer_mc #(
   parameter int  DATA_WIDTH   = 14,
   parameter int  NUM_CHANNELS = 2,
   parameter int  BATCH_SIZE   = 2048,
   parameter int  RUNS         = 3,
   localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int AW           = $clog2(BATCH_SIZE)
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               enable,
   input  logic                               sink_valid,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sink_data,
   input  logic                               source_ready,
   output logic                               source_valid,
   output logic                               source_sop,
   output logic                               source_eop,
   output logic [CH_W-1:0]                    source_channel,
   output logic [DATA_WIDTH-1:0]              source_data,
   output logic                               overflow,
   input  logic                               clear_overflow
);

   localparam int              WW       = NUM_CHANNELS * DATA_WIDTH;
   localparam int              RW       = (RUNS > 1) ? $clog2(RUNS) : 1;
   localparam logic [AW-1:0]   ADDR_LAST = AW'(BATCH_SIZE - 1);
   localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CHANNELS - 1);
   localparam logic [RW-1:0]   RUN_LAST  = RW'(RUNS - 1);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_t;
   typedef enum logic       {W_FILL, W_WAIT} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM, R_RELEASE} rstate_t;

   // Both banks share one array; the bank index is the top address bit.
   logic [WW-1:0]         r_mem [2*BATCH_SIZE];
   logic [WW-1:0]         r_mem_q;
   bank_t                 r_bank_st [2];
   logic                  r_oldest;

   wstate_t               r_wstate, w_wstate_next;
   logic                  r_wr_bank;
   logic [AW-1:0]         r_wr_addr;
   logic                  w_we, w_wr_done, w_drop, w_claim_bank, w_other;

   rstate_t               r_rstate, w_rstate_next;
   logic                  r_rd_bank;
   logic [AW-1:0]         r_rd_addr;
   logic [CH_W-1:0]       r_ch;
   logic [RW-1:0]         r_run;
   logic                  w_rd_pick, w_rd_sel, w_load, w_end;

   logic                  r_valid, r_sop, r_eop, r_last, r_overflow;
   logic [CH_W-1:0]       r_out_ch;
   logic [DATA_WIDTH-1:0] w_lane [NUM_CHANNELS];

   assign w_other = ~r_wr_bank;

   // Write FSM next state: fill the claimed bank, or wait (dropping) for a free one
   always_comb begin
      w_wstate_next = r_wstate;
      w_we          = 1'b0;
      w_wr_done     = 1'b0;
      w_drop        = 1'b0;
      w_claim_bank  = (r_bank_st[0] == B_EMPTY) ? 1'b0 : 1'b1;
      case (r_wstate)
         W_FILL: begin
            if (enable && sink_valid) begin
               w_we = 1'b1;
               if (r_wr_addr == ADDR_LAST) begin
                  w_wr_done = 1'b1;
                  if (r_bank_st[w_other] != B_EMPTY) w_wstate_next = W_WAIT;
               end
            end
         end
         W_WAIT: begin
            w_drop = enable & sink_valid;
            if (r_bank_st[0] == B_EMPTY || r_bank_st[1] == B_EMPTY) w_wstate_next = W_FILL;
         end
         default: w_wstate_next = W_FILL;
      endcase
   end

   // Write FSM state, write bank and write address; enable low discards the partial batch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wstate  <= W_FILL;
         r_wr_bank <= 1'b0;
         r_wr_addr <= '0;
      end else begin
         r_wstate <= w_wstate_next;
         if (r_wstate == W_FILL) begin
            if (!enable) begin
               r_wr_addr <= '0;
            end else if (w_we) begin
               if (w_wr_done) begin
                  r_wr_addr <= '0;
                  if (w_wstate_next == W_FILL) r_wr_bank <= w_other;
               end else begin
                  r_wr_addr <= r_wr_addr + 1'b1;
               end
            end
         end else if (w_wstate_next == W_FILL) begin
            r_wr_bank <= w_claim_bank;
            r_wr_addr <= '0;
         end
      end
   end

   // Bank ownership: reader takes/releases FULL banks, writer claims EMPTY and completes FILLING
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bank_st[0] <= B_EMPTY;
         r_bank_st[1] <= B_EMPTY;
         r_oldest     <= 1'b0;
      end else begin
         if (r_rstate == R_IDLE && w_rd_pick) r_bank_st[w_rd_sel] <= B_READING;
         if (r_rstate == R_RELEASE) r_bank_st[r_rd_bank] <= B_EMPTY;
         if (r_wstate == W_FILL && r_bank_st[r_wr_bank] == B_EMPTY)
            r_bank_st[r_wr_bank] <= B_FILLING;
         if (w_wr_done) begin
            r_bank_st[r_wr_bank] <= B_FULL;
            // The other bank already FULL means it is older and stays first in line.
            if (r_bank_st[w_other] != B_FULL) r_oldest <= r_wr_bank;
         end
      end
   end

   // Read FSM next state: pick oldest FULL bank, prime the RAM, stream, release
   always_comb begin
      w_rstate_next = r_rstate;
      w_load        = 1'b0;
      w_end         = 1'b0;
      w_rd_pick     = (r_bank_st[0] == B_FULL) || (r_bank_st[1] == B_FULL);
      w_rd_sel      = (r_bank_st[r_oldest] == B_FULL) ? r_oldest : ~r_oldest;
      case (r_rstate)
         R_IDLE:    if (w_rd_pick) w_rstate_next = R_FETCH;
         R_FETCH: begin
            w_load        = 1'b1;
            w_rstate_next = R_STREAM;
         end
         R_STREAM: begin
            if (source_ready) begin
               if (r_last) begin
                  w_end         = 1'b1;
                  w_rstate_next = R_RELEASE;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         R_RELEASE: w_rstate_next = R_IDLE;
         default:   w_rstate_next = R_IDLE;
      endcase
   end

   // Read pointers and output beat registers; everything advances only on w_load so a stall holds the beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rstate  <= R_IDLE;
         r_rd_bank <= 1'b0;
         r_rd_addr <= '0;
         r_ch      <= '0;
         r_run     <= '0;
         r_valid   <= 1'b0;
         r_sop     <= 1'b0;
         r_eop     <= 1'b0;
         r_last    <= 1'b0;
         r_out_ch  <= '0;
      end else begin
         r_rstate <= w_rstate_next;
         if (r_rstate == R_IDLE && w_rd_pick) begin
            r_rd_bank <= w_rd_sel;
            r_rd_addr <= '0;
            r_ch      <= '0;
            r_run     <= '0;
         end
         if (w_load) begin
            r_valid  <= 1'b1;
            r_sop    <= (r_rd_addr == '0);
            r_eop    <= (r_rd_addr == ADDR_LAST);
            r_out_ch <= r_ch;
            r_last   <= (r_rd_addr == ADDR_LAST) && (r_ch == CH_LAST) && (r_run == RUN_LAST);
            if (r_rd_addr == ADDR_LAST) begin
               r_rd_addr <= '0;
               if (r_ch == CH_LAST) begin
                  r_ch  <= '0;
                  r_run <= (r_run == RUN_LAST) ? '0 : r_run + 1'b1;
               end else begin
                  r_ch <= r_ch + 1'b1;
               end
            end else begin
               r_rd_addr <= r_rd_addr + 1'b1;
            end
         end
         if (w_end) begin
            r_valid  <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_last   <= 1'b0;
            r_out_ch <= '0;
         end
      end
   end

   // RAM write port
   always_ff @(posedge clk) begin
      if (w_we) r_mem[{r_wr_bank, r_wr_addr}] <= sink_data;
   end

   // RAM read port; its output register doubles as the held output word
   always_ff @(posedge clk) begin
      if (w_load) r_mem_q <= r_mem[{r_rd_bank, r_rd_addr}];
   end

   // Sticky overflow; a drop in the same cycle as a clear wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            r_overflow <= 1'b0;
      else if (w_drop)         r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
   end

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
      assign w_lane[gi] = r_mem_q[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Data is forced to zero when no beat is present so reset clears it without touching the RAM.
   assign source_data    = r_valid ? w_lane[r_out_ch] : '0;
   assign source_valid   = r_valid;
   assign source_sop     = r_sop;
   assign source_eop     = r_eop;
   assign source_channel = r_out_ch;
   assign overflow       = r_overflow;

endmodule
